// File: rtl/direct_mapped_cache_ctrl_pkg.sv
// Shared types and sizes for the direct-mapped cache controller and its backing memory.
package direct_mapped_cache_ctrl_pkg;

    localparam int unsigned ADDR_W          = 15;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned MEM_BLOCKS      = 8192;
    localparam int unsigned BLK_ADDR_W      = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        DONE
    } state_e;

    // Power-on image of a block: word at word address A holds {17'b0, A}.
    function automatic logic [BLOCK_W-1:0] init_block(input logic [BLK_ADDR_W-1:0] blk);
        logic [BLOCK_W-1:0] b;
        b = '0;
        for (int unsigned w = 0; w < WORDS_PER_BLOCK; w++) begin
            b[w*WORD_W +: WORD_W] = {17'b0, blk, w[1:0]};
        end
        return b;
    endfunction

endpackage

// File: rtl/direct_mapped_cache_ctrl_main_memory_block.sv
// Main memory: 8192 x 128-bit blocks, one synchronous read port and one write port.
module main_memory_block
    import direct_mapped_cache_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic [BLK_ADDR_W-1:0] rd_addr_i,
    output logic [BLOCK_W-1:0]    rd_data_o,
    input  logic                  wr_en_i,
    input  logic [BLK_ADDR_W-1:0] wr_addr_i,
    input  logic [BLOCK_W-1:0]    wr_data_i
);

    logic [BLOCK_W-1:0] mem_q [MEM_BLOCKS];

    // Contents are stored relative to the power-on image, so all-zero
    // power-up storage reads back as the required initial pattern.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i ^ init_block(wr_addr_i);
        end
        rd_data_o <= mem_q[rd_addr_i] ^ init_block(rd_addr_i);
    end

endmodule

// File: rtl/direct_mapped_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller over main_memory_block.
// Optional hit/miss counters are enabled with `define CACHE_STATS_EN.
module direct_mapped_cache_ctrl
    import direct_mapped_cache_ctrl_pkg::*;
#(
    parameter int unsigned INDEX_W = 5
) (
    input  logic               globalclock,
    input  logic               reset,
    input  logic               start,
    input  logic               wrEn,
    input  logic [ADDR_W-1:0]  address,
    output logic               done,
    output logic [WORD_W-1:0]  outData_cache,
    output logic [BLOCK_W-1:0] memOut
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    localparam int unsigned TAG_W = BLK_ADDR_W - INDEX_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                done_q;
    logic [WORD_W-1:0]   out_q, out_d;
    logic [BLOCK_W-1:0]  memout_q, memout_d;

    logic [LINES-1:0]    valid_q, dirty_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [BLOCK_W-1:0]  data_q [LINES];

    logic [1:0]          off;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    cur_tag;
    logic [BLOCK_W-1:0]  line_data, line_wdata, mem_rd;
    logic [WORD_W-1:0]   cur_word;
    logic                hit, line_we, alloc, hit_wr, mem_we;

    assign off       = addr_q[1:0];
    assign idx       = addr_q[INDEX_W+1:2];
    assign cur_tag   = addr_q[ADDR_W-1:INDEX_W+2];
    assign line_data = data_q[idx];
    assign cur_word  = line_data[off*WORD_W +: WORD_W];
    assign hit       = valid_q[idx] && (tag_q[idx] == cur_tag);

    main_memory_block u_mem (
        .clk_i     (globalclock),
        .rd_addr_i (addr_q[ADDR_W-1:2]),
        .rd_data_o (mem_rd),
        .wr_en_i   (mem_we),
        .wr_addr_i ({tag_q[idx], idx}),
        .wr_data_i (line_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        out_d      = out_q;
        memout_d   = memout_q;
        line_wdata = line_data;
        line_we    = 1'b0;
        alloc      = 1'b0;
        hit_wr     = 1'b0;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address;
                    wr_d    = wrEn;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (wr_q) begin
                        line_wdata[off*WORD_W +: WORD_W] = cur_word + 32'd1;
                        line_we = 1'b1;
                        hit_wr  = 1'b1;
                        out_d   = cur_word + 32'd1;
                    end else begin
                        out_d = cur_word;
                    end
                    state_d = DONE;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_we  = 1'b1;
                state_d = ALLOCATE;
            end
            ALLOCATE: begin
                line_wdata = mem_rd;
                line_we    = 1'b1;
                alloc      = 1'b1;
                memout_d   = mem_rd;
                state_d    = COMPARE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            memout_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            done_q   <= (state_q == DONE);
            out_q    <= out_d;
            memout_q <= memout_d;
            if (alloc) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (hit_wr) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge globalclock) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
        end
        if (alloc) begin
            tag_q[idx] <= cur_tag;
        end
    end

    assign done          = done_q;
    assign outData_cache = out_q;
    assign memOut        = memout_q;

`ifdef CACHE_STATS_EN
    logic        first_q;
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Only the first COMPARE of a request is classified; the re-compare after ALLOCATE is not.
    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            first_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                first_q <= 1'b1;
            end else if (state_q == COMPARE) begin
                first_q <= 1'b0;
                if (first_q) begin
                    if (hit && hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_q <= hit_cnt_q + 16'd1;
                    end else if (!hit && miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_q <= miss_cnt_q + 16'd1;
                    end
                end
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
`endif

endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// Directed self-checking bench for direct_mapped_cache_ctrl (default build).
module tb_direct_mapped_cache_ctrl;

    logic         globalclock = 1'b0;
    logic         reset;
    logic         start;
    logic         wrEn;
    logic [14:0]  address;
    logic         done;
    logic [31:0]  outData_cache;
    logic [127:0] memOut;

    int checks = 0;
    int errors = 0;

    direct_mapped_cache_ctrl #(.INDEX_W(5)) dut (
        .globalclock   (globalclock),
        .reset         (reset),
        .start         (start),
        .wrEn          (wrEn),
        .address       (address),
        .done          (done),
        .outData_cache (outData_cache),
        .memOut        (memOut)
    );

    always #5 globalclock = ~globalclock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk(input logic [31:0] w3, input logic [31:0] w2,
                                         input logic [31:0] w1, input logic [31:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    // Issue one request, measure edges from the sampling edge to done, then check outputs.
    task automatic do_req(input string tag, input logic w, input logic [14:0] a,
                          input int lat, input logic [31:0] d, input logic [127:0] m);
        int n;
        @(negedge globalclock);
        start   = 1'b1;
        wrEn    = w;
        address = a;
        @(posedge globalclock);
        #1 start = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge globalclock);
            #1 n++;
            if (done) break;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        chk({tag, "_data"}, 128'(outData_cache), 128'(d));
        chk({tag, "_mem"}, memOut, m);
        @(posedge globalclock);
        #1 chk({tag, "_pulse"}, 128'(done), 128'(0));
    endtask

    initial begin
        logic [11:0] pat;
        logic        seen;

        reset = 1'b1; start = 1'b0; wrEn = 1'b0; address = '0;
        #12;
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_data", 128'(outData_cache), 128'(0));
        chk("rst_mem", memOut, 128'(0));
        @(negedge globalclock);
        reset = 1'b0;

        do_req("rd0", 1'b0, 15'h0000, 4, 32'h0, blk(32'h3, 32'h2, 32'h1, 32'h0));
        do_req("rd7833_miss", 1'b0, 15'h7833, 4, 32'h7833,
               blk(32'h7833, 32'h7832, 32'h7831, 32'h7830));
        do_req("rd7833_hit", 1'b0, 15'h7833, 2, 32'h7833,
               blk(32'h7833, 32'h7832, 32'h7831, 32'h7830));
        do_req("wr7833", 1'b1, 15'h7833, 2, 32'h7834,
               blk(32'h7833, 32'h7832, 32'h7831, 32'h7830));
        do_req("rd7833_after_wr", 1'b0, 15'h7833, 2, 32'h7834,
               blk(32'h7833, 32'h7832, 32'h7831, 32'h7830));
        do_req("rd0033_dirty", 1'b0, 15'h0033, 5, 32'h33,
               blk(32'h33, 32'h32, 32'h31, 32'h30));
        do_req("rd7833_wb", 1'b0, 15'h7833, 4, 32'h7834,
               blk(32'h7834, 32'h7832, 32'h7831, 32'h7830));

        // Reset while the controller sits in ALLOCATE.
        @(negedge globalclock);
        start = 1'b1; wrEn = 1'b0; address = 15'h0100;
        @(posedge globalclock);
        #1 start = 1'b0;
        @(posedge globalclock);
        #1 reset = 1'b1;
        #1;
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_data", 128'(outData_cache), 128'(0));
        chk("midrst_mem", memOut, 128'(0));
        @(negedge globalclock);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge globalclock);
            #1 if (done) seen = 1'b1;
        end
        chk("midrst_nodone", 128'(seen), 128'(0));

        do_req("rd0100_after_rst", 1'b0, 15'h0100, 4, 32'h100,
               blk(32'h103, 32'h102, 32'h101, 32'h100));
        do_req("rd7833_after_rst", 1'b0, 15'h7833, 4, 32'h7834,
               blk(32'h7834, 32'h7832, 32'h7831, 32'h7830));
        do_req("rd0100_hit", 1'b0, 15'h0100, 2, 32'h100,
               blk(32'h7834, 32'h7832, 32'h7831, 32'h7830));

        // start held high: three hits sampled at edges k, k+3, k+6.
        @(negedge globalclock);
        start = 1'b1; wrEn = 1'b0; address = 15'h0100;
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge globalclock);
            #1 pat[i] = done;
            if (i == 6) start = 1'b0;
        end
        chk("held_start_pattern", 128'(pat), 128'(12'h124));
        chk("held_start_data", 128'(outData_cache), 128'(32'h100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
